load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: validates a RISC-V load/store request, performs one data-memory
// access and returns the extended load result or a single fault flag.
module load_store_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 32768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_fn3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_misaligned,
  output logic        resp_illegal,
  output logic        resp_oob,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr_en,
  output logic [2:0]  mem_fn3,
  input  logic [31:0] mem_rdata
);
  localparam int unsigned AW = 32;
  localparam int unsigned RW = 5;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t        r_state;
  logic          r_we;
  logic [RW-1:0] r_rd;

  logic [AW:0]   w_offset;
  logic          w_illegal;
  logic          w_misaligned;
  logic          w_oob;
  logic          w_fault;

  // 33-bit offset: an address below BASE_ADDR borrows into bit 32, so a single
  // unsigned compare against MEM_BYTES catches both ends without wrap.
  assign w_offset = {1'b0, req_addr} - {1'b0, BASE_ADDR};

  always_comb begin
    w_illegal    = req_we ? (req_fn3 > 3'd2)
                          : (req_fn3 == 3'd3 || req_fn3 == 3'd6 || req_fn3 == 3'd7);
    w_misaligned = 1'b0;
    if (!w_illegal) begin
      if (req_fn3[1:0] == 2'd1)      w_misaligned = req_addr[0];
      else if (req_fn3[1:0] == 2'd2) w_misaligned = (req_addr[1:0] != 2'b00);
    end
    w_oob   = !w_illegal && !w_misaligned && (w_offset >= (AW+1)'(MEM_BYTES));
    w_fault = w_illegal || w_misaligned || w_oob;
  end

  // Write strobe decodes straight from the state so an async reset kills it at once.
  assign mem_wr_en = (r_state == ISSUE) && r_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_we            <= 1'b0;
      r_rd            <= '0;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_data       <= '0;
      resp_rd         <= '0;
      resp_misaligned <= 1'b0;
      resp_illegal    <= 1'b0;
      resp_oob        <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_fn3         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            r_we      <= req_we;
            r_rd      <= req_rd;
            if (w_fault) begin
              resp_valid      <= 1'b1;
              resp_data       <= '0;
              resp_rd         <= '0;
              resp_illegal    <= w_illegal;
              resp_misaligned <= w_misaligned;
              resp_oob        <= w_oob;
              r_state         <= RESP;
            end else begin
              mem_addr  <= w_offset[AW-1:0];
              mem_fn3   <= req_fn3;
              mem_wdata <= req_wdata;
              r_state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (r_we) begin
            resp_valid <= 1'b1;
            resp_data  <= '0;
            resp_rd    <= '0;
            r_state    <= RESP;
          end else begin
            r_state <= CAPTURE;
          end
        end
        CAPTURE: begin
          resp_valid <= 1'b1;
          resp_data  <= mem_rdata;
          resp_rd    <= r_rd;
          r_state    <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid      <= 1'b0;
            resp_data       <= '0;
            resp_rd         <= '0;
            resp_misaligned <= 1'b0;
            resp_illegal    <= 1'b0;
            resp_oob        <= 1'b0;
            req_ready       <= 1'b1;
            r_state         <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
